// File: rtl/axis_data_receiver.sv
// AXI-Stream sink from the PS: buffers beats in a first-word-fall-through FIFO,
// enforces a maximum packet length, checks tkeep and counts stored packets.
`timescale 1ns/1ps
module axis_data_receiver #(
  parameter int AXIS_DATA_WIDTH  = 256,
  parameter int AXIS_DATA_KEEP   = 32,
  parameter int FIFO_DEPTH_INDEX = 4,
  parameter int MAX_PACKET_BEATS = 400
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [AXIS_DATA_KEEP-1:0]   s_axis_tkeep,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic                        receive_vld,
  output logic [AXIS_DATA_WIDTH-1:0]  receive_data,
  output logic [AXIS_DATA_KEEP-1:0]   receive_keep,
  output logic                        receive_last,
  input  logic                        receive_rdy,
  input  logic                        err_clr,
  output logic                        keep_err,
  output logic                        overlen_err,
  output logic [15:0]                 pkt_cnt,
  output logic [FIFO_DEPTH_INDEX:0]   fifo_count
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_INDEX;
  localparam int ENTRY_W = AXIS_DATA_WIDTH + AXIS_DATA_KEEP + 1;
  localparam int CNT_W   = $clog2(MAX_PACKET_BEATS + 1);
  localparam logic [CNT_W-1:0]          MAX_BEATS = CNT_W'(MAX_PACKET_BEATS);
  localparam logic [FIFO_DEPTH_INDEX:0] FULL_CNT  = (FIFO_DEPTH_INDEX + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            beat_cnt_q, beat_cnt_d, beat_num;
  logic [FIFO_DEPTH_INDEX-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_INDEX:0]   count_q, count_d;
  logic [15:0]                 pkt_cnt_q, pkt_cnt_d;
  logic                        keep_err_q, keep_err_d;
  logic                        overlen_err_q, overlen_err_d;
  logic [ENTRY_W-1:0]          fifo_mem_q [DEPTH];
  logic [ENTRY_W-1:0]          rd_entry;
  logic                        full, empty, accept, wr_en, rd_en;
  logic                        wr_last, force_last, keep_bad;

  assign full          = (count_q == FULL_CNT);
  assign empty         = (count_q == '0);
  // DROP keeps draining the PS even when the FIFO is full, since nothing is stored
  assign s_axis_tready = !rst && ((state_q == DROP) || !full);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign rd_en         = !empty && receive_rdy;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    wr_en      = 1'b0;
    wr_last    = s_axis_tlast;
    force_last = 1'b0;
    beat_num   = (state_q == IDLE) ? CNT_W'(1) : beat_cnt_q + CNT_W'(1);
    if (accept) begin
      case (state_q)
        DROP: begin
          if (s_axis_tlast) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end
        end
        default: begin
          wr_en = 1'b1;
          if (s_axis_tlast) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else if (beat_num == MAX_BEATS) begin
            force_last = 1'b1;
            wr_last    = 1'b1;
            state_d    = DROP;
            beat_cnt_d = '0;
          end else begin
            state_d    = BODY;
            beat_cnt_d = beat_num;
          end
        end
      endcase
    end
  end

  always_comb begin
    keep_bad      = wr_en && !wr_last && (s_axis_tkeep != {AXIS_DATA_KEEP{1'b1}});
    keep_err_d    = (keep_err_q && !err_clr) || keep_bad;
    overlen_err_d = (overlen_err_q && !err_clr) || force_last;
    pkt_cnt_d     = (wr_en && wr_last) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    wr_ptr_d      = wr_en ? wr_ptr_q + FIFO_DEPTH_INDEX'(1) : wr_ptr_q;
    rd_ptr_d      = rd_en ? rd_ptr_q + FIFO_DEPTH_INDEX'(1) : rd_ptr_q;
    count_d       = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pkt_cnt_q     <= '0;
      keep_err_q    <= 1'b0;
      overlen_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pkt_cnt_q     <= pkt_cnt_d;
      keep_err_q    <= keep_err_d;
      overlen_err_q <= overlen_err_d;
    end
  end

  // Storage is not reset; an empty FIFO masks it on the outputs instead
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem_q[wr_ptr_q] <= {wr_last, s_axis_tkeep, s_axis_tdata};
  end

  assign rd_entry     = empty ? '0 : fifo_mem_q[rd_ptr_q];
  assign receive_vld  = !empty;
  assign receive_data = rd_entry[AXIS_DATA_WIDTH-1:0];
  assign receive_keep = rd_entry[AXIS_DATA_WIDTH +: AXIS_DATA_KEEP];
  assign receive_last = rd_entry[ENTRY_W-1];
  assign keep_err     = keep_err_q;
  assign overlen_err  = overlen_err_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign fifo_count   = count_q;

endmodule
